vga_fb_arbiter: RTL and testbench

Framebuffer access arbiter and scheduler between the VGA timing generator and a single-port synchronous block RAM holding an 80x60 grid of 8x8-pixel colour cells (9-bit RGB 3:3:3). It guarantees display cell fetches on fixed slots locked to the raster position. It shares the remaining RAM cycles between a host write port and a host read port using round-robin arbitration. It also runs a hardware clear-screen sweep.

---
 rtl/vga_fb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM scheduler: raster-locked display cell fetches, round-robin
// host write/read ports on the free cycles, and a hardware clear-screen sweep.
module vga_fb_arbiter #(
    parameter int CELLS = 4800
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [11:0] i_HPos,
    input  logic [11:0] i_VPos,
    output logic [12:0] o_Mem_Addr,
    output logic        o_Mem_WrEn,
    output logic [8:0]  o_Mem_WrData,
    input  logic [8:0]  i_Mem_RdData,
    output logic [8:0]  o_Cell_Data,
    input  logic        i_Wr_Valid,
    output logic        o_Wr_Ready,
    input  logic [12:0] i_Wr_Addr,
    input  logic [8:0]  i_Wr_Data,
    input  logic        i_Rd_Valid,
    output logic        o_Rd_Ready,
    input  logic [12:0] i_Rd_Addr,
    output logic        o_Rd_Data_Valid,
    output logic [8:0]  o_Rd_Data,
    input  logic        i_Clear,
    input  logic [8:0]  i_Clear_Colour,
    output logic        o_Busy
);

    localparam logic [12:0] CELLS_L = 13'(CELLS);
    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_CLEAR = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [12:0] clr_cnt_q, clr_cnt_d;
    logic [8:0]  clr_colour_q, clr_colour_d;
    logic        rr_rd_q, rr_rd_d;
    logic [12:0] mem_addr_q, mem_addr_d;
    logic        mem_wren_q, mem_wren_d;
    logic [8:0]  mem_wrdata_q, mem_wrdata_d;
    logic        disp_p1_q, disp_p1_d;
    logic        disp_p2_q;
    logic        rd_p1_q, rd_p1_d;
    logic        rd_p2_q;
    logic        rd_oob_p1_q, rd_oob_p1_d;
    logic        rd_oob_p2_q;
    logic        rd_valid_q, rd_valid_d;
    logic [8:0]  rd_data_q, rd_data_d;
    logic [8:0]  cell_q, cell_d;

    logic        col_slot, col0_slot, slot, free;
    logic [11:0] fetch_line;
    logic [6:0]  fetch_col;
    logic [12:0] row13, disp_addr;
    logic        wr_win, rd_win, wr_fire, rd_fire;

    // Column c is fetched at HPos 8c-3; column 0 wraps to HPos 797 of the previous line.
    always_comb begin
        col_slot   = (i_VPos < 12'd480) && (i_HPos[2:0] == 3'd5) && (i_HPos <= 12'd629);
        col0_slot  = (i_HPos == 12'd797) && ((i_VPos < 12'd479) || (i_VPos == 12'd524));
        slot       = col_slot || col0_slot;
        fetch_line = col0_slot ? ((i_VPos == 12'd524) ? 12'd0 : i_VPos + 12'd1) : i_VPos;
        fetch_col  = col0_slot ? 7'd0 : i_HPos[9:3] + 7'd1;
        row13      = {1'b0, fetch_line} >> 3;
        disp_addr  = (row13 << 6) + (row13 << 4) + {6'b0, fetch_col};
    end

    assign free       = !slot && (state_q == ST_IDLE);
    assign wr_win     = i_Wr_Valid && (!i_Rd_Valid || !rr_rd_q);
    assign rd_win     = i_Rd_Valid && (!i_Wr_Valid || rr_rd_q);
    assign o_Wr_Ready = free && wr_win;
    assign o_Rd_Ready = free && rd_win;
    assign wr_fire    = i_Wr_Valid && o_Wr_Ready;
    assign rd_fire    = i_Rd_Valid && o_Rd_Ready;

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clr_colour_d = clr_colour_q;
        rr_rd_d      = rr_rd_q;
        mem_addr_d   = mem_addr_q;
        mem_wren_d   = 1'b0;
        mem_wrdata_d = mem_wrdata_q;
        disp_p1_d    = 1'b0;
        rd_p1_d      = 1'b0;
        rd_oob_p1_d  = 1'b0;

        if (slot) begin
            mem_addr_d = disp_addr;
            disp_p1_d  = 1'b1;
        end else if (state_q == ST_CLEAR) begin
            mem_addr_d   = clr_cnt_q;
            mem_wren_d   = 1'b1;
            mem_wrdata_d = clr_colour_q;
            clr_cnt_d    = clr_cnt_q + 13'd1;
            if (clr_cnt_q == CELLS_L - 13'd1) begin
                state_d = ST_IDLE;
            end
        end else if (wr_fire) begin
            rr_rd_d = 1'b1;
            if (i_Wr_Addr < CELLS_L) begin
                mem_addr_d   = i_Wr_Addr;
                mem_wren_d   = 1'b1;
                mem_wrdata_d = i_Wr_Data;
            end
        end else if (rd_fire) begin
            rr_rd_d     = 1'b0;
            rd_p1_d     = 1'b1;
            rd_oob_p1_d = (i_Rd_Addr >= CELLS_L);
            if (i_Rd_Addr < CELLS_L) begin
                mem_addr_d = i_Rd_Addr;
            end
        end

        if ((state_q == ST_IDLE) && i_Clear) begin
            state_d      = ST_CLEAR;
            clr_cnt_d    = 13'd0;
            clr_colour_d = i_Clear_Colour;
        end

        cell_d     = disp_p2_q ? i_Mem_RdData : cell_q;
        rd_valid_d = rd_p2_q;
        rd_data_d  = rd_p2_q ? (rd_oob_p2_q ? 9'd0 : i_Mem_RdData) : rd_data_q;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= 13'd0;
            clr_colour_q <= 9'd0;
            rr_rd_q      <= 1'b0;
            mem_addr_q   <= 13'd0;
            mem_wren_q   <= 1'b0;
            mem_wrdata_q <= 9'd0;
            disp_p1_q    <= 1'b0;
            disp_p2_q    <= 1'b0;
            rd_p1_q      <= 1'b0;
            rd_p2_q      <= 1'b0;
            rd_oob_p1_q  <= 1'b0;
            rd_oob_p2_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 9'd0;
            cell_q       <= 9'd0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_colour_q <= clr_colour_d;
            rr_rd_q      <= rr_rd_d;
            mem_addr_q   <= mem_addr_d;
            mem_wren_q   <= mem_wren_d;
            mem_wrdata_q <= mem_wrdata_d;
            disp_p1_q    <= disp_p1_d;
            disp_p2_q    <= disp_p1_q;
            rd_p1_q      <= rd_p1_d;
            rd_p2_q      <= rd_p1_q;
            rd_oob_p1_q  <= rd_oob_p1_d;
            rd_oob_p2_q  <= rd_oob_p1_q;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            cell_q       <= cell_d;
        end
    end

    assign o_Mem_Addr      = mem_addr_q;
    assign o_Mem_WrEn      = mem_wren_q;
    assign o_Mem_WrData    = mem_wrdata_q;
    assign o_Cell_Data     = cell_q;
    assign o_Rd_Data_Valid = rd_valid_q;
    assign o_Rd_Data       = rd_data_q;
    assign o_Busy          = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a RAM model and a write/read scoreboard.
module tb_vga_fb_arbiter;

    localparam int CELLS = 4800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] hpos, vpos;
    logic [12:0] mem_addr;
    logic        mem_wren;
    logic [8:0]  mem_wrdata, mem_rddata, cell_data;
    logic        wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid;
    logic [12:0] wr_addr, rd_addr;
    logic [8:0]  wr_data, rd_data;
    logic        clear, busy;
    logic [8:0]  clear_colour;
    logic        ram_init;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.CELLS(CELLS)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HPos(hpos), .i_VPos(vpos),
        .o_Mem_Addr(mem_addr), .o_Mem_WrEn(mem_wren), .o_Mem_WrData(mem_wrdata),
        .i_Mem_RdData(mem_rddata), .o_Cell_Data(cell_data),
        .i_Wr_Valid(wr_valid), .o_Wr_Ready(wr_ready), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
        .i_Rd_Valid(rd_valid), .o_Rd_Ready(rd_ready), .i_Rd_Addr(rd_addr),
        .o_Rd_Data_Valid(rd_data_valid), .o_Rd_Data(rd_data),
        .i_Clear(clear), .i_Clear_Colour(clear_colour), .o_Busy(busy)
    );

    // Synchronous single-port RAM: data is valid the cycle after the address.
    logic [8:0] ram [0:CELLS-1];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < CELLS; i++) ram[i] <= i[8:0];
        end else if (mem_wren && mem_addr < CELLS) begin
            ram[mem_addr] <= mem_wrdata;
        end
        mem_rddata <= (mem_addr < CELLS) ? ram[mem_addr] : 9'd0;
    end

    typedef struct {logic [12:0] addr; logic [8:0] data; int cyc;} wr_exp_t;
    typedef struct {logic [8:0] data; int cyc;} rd_exp_t;
    wr_exp_t    wq[$];
    rd_exp_t    rq[$];
    logic [8:0] shadow [0:CELLS-1];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    function automatic bit is_slot(input logic [11:0] h, input logic [11:0] v);
        return (v < 480 && h[2:0] == 3'd5 && h >= 5 && h <= 629) ||
               (h == 797 && (v < 479 || v == 524));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, check scoreboarded RAM writes and read results, step the raster.
    task automatic tick();
        wr_exp_t we;
        rd_exp_t re;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_wren) begin
            chk("wr_not_on_slot", {31'd0, is_slot(hpos, vpos)}, 0);
            chk("wr_expected", {31'd0, wq.size() > 0}, 1);
            if (wq.size() > 0) begin
                we = wq.pop_front();
                chk("wr_addr", {19'd0, mem_addr}, {19'd0, we.addr});
                chk("wr_data", {23'd0, mem_wrdata}, {23'd0, we.data});
                if (we.cyc >= 0) chk("wr_latency", cyc, we.cyc);
            end
        end
        if (rd_data_valid) begin
            chk("rd_expected", {31'd0, rq.size() > 0}, 1);
            if (rq.size() > 0) begin
                re = rq.pop_front();
                chk("rd_data", {23'd0, rd_data}, {23'd0, re.data});
                chk("rd_latency", cyc, re.cyc);
            end
        end
        if (hpos == 12'd799) begin
            hpos = 12'd0;
            vpos = (vpos == 12'd524) ? 12'd0 : vpos + 12'd1;
        end else begin
            hpos = hpos + 12'd1;
        end
    endtask

    task automatic host_wr(input logic [12:0] a, input logic [8:0] d);
        int n = 0;
        bit done = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        while (!done && n < 64) begin
            #1;
            if (wr_ready) begin
                done = 1;
                if (a < CELLS) begin
                    shadow[a] = d;
                    wq.push_back('{addr: a, data: d, cyc: cyc + 1});
                end
            end
            tick();
            n++;
        end
        wr_valid = 1'b0;
        chk("wr_handshake", {31'd0, done}, 1);
    endtask

    task automatic host_rd(input logic [12:0] a);
        int n = 0;
        bit done = 0;
        rd_valid = 1'b1; rd_addr = a;
        while (!done && n < 64) begin
            #1;
            if (rd_ready) begin
                done = 1;
                rq.push_back('{data: (a < CELLS) ? shadow[a] : 9'd0, cyc: cyc + 3});
            end
            tick();
            n++;
        end
        rd_valid = 1'b0;
        chk("rd_handshake", {31'd0, done}, 1);
    endtask

    function automatic logic [47:0] all_outs();
        return {mem_addr, mem_wren, mem_wrdata, cell_data, rd_data_valid, rd_data,
                busy, wr_ready, rd_ready, 3'd0};
    endfunction

    initial begin
        int busy_n, slot_n, n, c0;
        bit last_w, exp_s, exp_w;
        hpos = 12'd100; vpos = 12'd100;
        wr_valid = 0; wr_addr = 0; wr_data = 0;
        rd_valid = 0; rd_addr = 0;
        clear = 0; clear_colour = 0; ram_init = 1'b1;
        for (int i = 0; i < CELLS; i++) shadow[i] = i[8:0];

        #2;
        chk("reset_outputs", all_outs(), 0);
        tick();
        ram_init = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-line with a read in flight: outputs clear at once, result dropped.
        host_rd(13'd50);
        rst_n = 1'b0;
        #1;
        chk("midline_reset_outputs", all_outs(), 0);
        rq.delete();
        tick();
        tick();
        chk("rd_dropped", {31'd0, rd_data_valid}, 0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_no_wren", {31'd0, mem_wren}, 0);

        // Both ports valid over HPos 0..31: strict alternation from write, none on slots.
        hpos = 12'd0; vpos = 12'd100;
        last_w = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_addr = 13'(4000 + i); wr_data = 9'(i);
            rd_valid = 1'b1; rd_addr = 13'(4100 + i);
            #1;
            exp_s = is_slot(hpos, vpos);
            exp_w = !exp_s && !last_w;
            chk("arb_wr_ready", {31'd0, wr_ready}, {31'd0, exp_w});
            chk("arb_rd_ready", {31'd0, rd_ready}, {31'd0, !exp_s && last_w});
            if (wr_ready) begin
                shadow[wr_addr] = wr_data;
                wq.push_back('{addr: wr_addr, data: wr_data, cyc: cyc + 1});
            end
            if (rd_ready) rq.push_back('{data: shadow[rd_addr], cyc: cyc + 3});
            if (!exp_s) last_w = exp_w;
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        repeat (6) tick();
        chk("arb_wq_empty", wq.size(), 0);
        chk("arb_rq_empty", rq.size(), 0);

        // Display fetch alignment against the preloaded cell = index pattern.
        hpos = 12'd0; vpos = 12'd16;
        repeat (8) tick();
        chk("cell_r2_c1", {23'd0, cell_data}, 161);
        repeat (8) tick();
        chk("cell_r2_c2", {23'd0, cell_data}, 162);
        repeat (616) tick();
        chk("cell_r2_c79", {23'd0, cell_data}, 239);
        hpos = 12'd790; vpos = 12'd524;
        repeat (10) tick();
        chk("cell_line0_c0", {23'd0, cell_data}, 0);
        repeat (8) tick();
        chk("cell_line0_c1", {23'd0, cell_data}, 1);

        // Boundary addresses: last cell round-trips, out-of-range write ignored, read 0.
        hpos = 12'd0; vpos = 12'd200;
        host_wr(13'd4799, 9'h1FF);
        host_rd(13'd4799);
        host_wr(13'd4800, 9'h055);
        host_rd(13'd4800);
        host_rd(13'd161);
        repeat (6) tick();
        chk("bnd_wq_empty", wq.size(), 0);
        chk("bnd_rq_empty", rq.size(), 0);

        // Clear sweep in vertical blank: 4800 back-to-back writes, host stalled.
        hpos = 12'd0; vpos = 12'd480;
        clear = 1'b1; clear_colour = 9'h0A5;
        c0 = cyc;
        for (int k = 0; k < CELLS; k++) begin
            shadow[k] = 9'h0A5;
            wq.push_back('{addr: 13'(k), data: 9'h0A5, cyc: c0 + 2 + k});
        end
        tick();
        clear = 1'b0; clear_colour = 9'h000;
        chk("clr1_busy_rise", {31'd0, busy}, 1);
        busy_n = 0; n = 0;
        while (busy && n < 6000) begin
            busy_n++;
            wr_valid = 1'b1; wr_addr = 13'd7; wr_data = 9'h1;
            rd_valid = 1'b1; rd_addr = 13'd8;
            #1;
            chk("clr1_ready_low", {30'd0, wr_ready, rd_ready}, 0);
            tick();
            n++;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        chk("clr1_busy_cycles", busy_n, 4800);
        chk("clr1_wq_empty", wq.size(), 0);
        host_rd(13'd123);
        host_rd(13'd4799);
        repeat (6) tick();
        chk("clr1_rq_empty", rq.size(), 0);

        // Clear sweep across active lines: slots skipped, a second request ignored.
        hpos = 12'd0; vpos = 12'd470;
        clear = 1'b1; clear_colour = 9'h15A;
        for (int k = 0; k < CELLS; k++) begin
            shadow[k] = 9'h15A;
            wq.push_back('{addr: 13'(k), data: 9'h15A, cyc: -1});
        end
        tick();
        clear = 1'b0;
        busy_n = 0; slot_n = 0; n = 0;
        while (busy && n < 8000) begin
            busy_n++;
            if (is_slot(hpos, vpos)) slot_n++;
            if (busy_n == 1000) begin
                clear = 1'b1; clear_colour = 9'h0FF;
            end else begin
                clear = 1'b0;
            end
            tick();
            n++;
        end
        clear = 1'b0;
        chk("clr2_busy_fell", {31'd0, busy}, 0);
        chk("clr2_write_cycles", busy_n - slot_n, 4800);
        chk("clr2_wq_empty", wq.size(), 0);
        host_rd(13'd0);
        host_rd(13'd4799);
        repeat (6) tick();
        chk("clr2_rq_empty", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
